ks_add_scheduler: RTL

Shared-adder scheduler: arbitrates up to NREQ requesters onto a single `kogge_stone_16` instance and sequences each WIDTH-bit add/subtract over WIDTH/16 cycles.
- Carry is registered between 16-bit chunks.
- Assembled sum, carry-out and signed-overflow flags are returned on a single valid/ready response port.
- Sits between multiplier partial-product/accumulate logic and the fast-adder library; it lets several consumers share one adder.

---
 rtl/ks_add_scheduler_pkg.sv | 19 +
 rtl/kogge_stone_16.sv | 34 +++
 rtl/ks_add_scheduler_arb.sv | 41 ++++
 rtl/ks_add_scheduler.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ks_add_scheduler_pkg.sv
// ks_sched_pkg: shared definitions for the shared-adder scheduler.
//   CHUNK_W          width of one pass through the 16-bit prefix adder
//   ks_sched_state_t scheduler FSM states
//   chunk_count()    number of adder passes needed for a given operand width
package ks_sched_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_sched_state_t;

    function automatic int chunk_count(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/kogge_stone_16.sv
// kogge_stone_16: 16-bit Kogge-Stone parallel-prefix adder, purely combinational.
//   a, b  : 16-bit operands
//   cin   : carry in
//   sum   : a + b + cin (low 16 bits)
//   cout  : carry out of bit 15
module kogge_stone_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    always_comb begin
        logic [15:0] g, p, gn, pn;
        g = a & b;
        p = a ^ b;
        // Fold cin into bit 0's generate so the prefix tree yields carries directly.
        g[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < 4; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        sum  = (a ^ b) ^ {g[14:0], cin};
        cout = g[15];
    end

endmodule

// File: rtl/ks_add_scheduler_arb.sv
// ks_rr_arbiter: combinational round-robin arbiter.
//   req        : request vector
//   last_grant : index of the previously served requester
//   grant      : one-hot grant (zero when no request)
//   grant_id   : encoded index of the granted requester
// Search begins at last_grant+1 and wraps modulo NREQ.
module ks_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NREQ);

    always_comb begin
        int start;
        int idx;
        logic [NREQ-1:0] rot;
        logic [NREQ-1:0] tmp;
        grant    = '0;
        grant_id = '0;
        start    = (int'(last_grant) >= NREQ - 1) ? 0 : int'(last_grant) + 1;
        // Rotate so bit 0 is the highest-priority requester this cycle.
        rot = NREQ'({req, req} >> start);
        idx = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            tmp = rot >> k;
            if (tmp[0]) idx = k;
        end
        if (idx >= 0) begin
            idx = idx + start;
            if (idx >= NREQ) idx = idx - NREQ;
            grant    = NREQ'(1) << idx;
            grant_id = IDW'(idx);
        end
    end

endmodule

// File: rtl/ks_add_scheduler.sv
// ks_add_scheduler: shares one kogge_stone_16 among NREQ requesters.
// A granted WIDTH-bit add/subtract runs 16 bits per cycle with the carry
// registered between chunks, then the result is offered on a valid/ready port.
//   clk, rst            clock, async active-high reset
//   req_valid/req_ready per-requester handshake (ready is a one-hot grant)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready response handshake
//   rsp_id              served requester
//   rsp_sum/cout/ovf    result, MSB carry (1 = no borrow on subtract), signed overflow
module ks_add_scheduler
    import ks_sched_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ-1:0]           req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_ovf
);

    localparam int IDW = $clog2(NREQ);
    localparam int K   = chunk_count(WIDTH);
    localparam int CW  = (K > 1) ? $clog2(K) : 1;

    ks_sched_state_t state, state_nxt;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             carry_q;
    logic [CW-1:0]    chunk_q;
    logic             last_chunk;

    logic [CHUNK_W-1:0] ks_a, ks_b, ks_sum;
    logic               ks_cout;

    ks_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign grant_any  = |grant;
    assign last_chunk = (chunk_q == CW'(K - 1));

    assign ks_a = a_q[int'(chunk_q)*CHUNK_W +: CHUNK_W];
    assign ks_b = b_q[int'(chunk_q)*CHUNK_W +: CHUNK_W];

    kogge_stone_16 u_add (
        .a    (ks_a),
        .b    (ks_b),
        .cin  (carry_q),
        .sum  (ks_sum),
        .cout (ks_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any)  state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (rsp_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; grant is masked during reset so nothing handshakes then.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        if (state == IDLE && !rst) req_ready = grant;
        if (state == DONE)         rsp_valid = 1'b1;
    end

    // Operand capture and chunked datapath.
    // B is inverted at capture and carry seeded with sub, so subtract is A + ~B + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            chunk_q    <= '0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (state == IDLE && grant_any) begin
            a_q        <= req_a[int'(grant_id)*WIDTH +: WIDTH];
            b_q        <= req_sub[grant_id] ? ~req_b[int'(grant_id)*WIDTH +: WIDTH]
                                            :  req_b[int'(grant_id)*WIDTH +: WIDTH];
            carry_q    <= req_sub[grant_id];
            chunk_q    <= '0;
            id_q       <= grant_id;
            last_grant <= grant_id;
        end else if (state == RUN) begin
            result_q[int'(chunk_q)*CHUNK_W +: CHUNK_W] <= ks_sum;
            carry_q <= ks_cout;
            chunk_q <= chunk_q + 1'b1;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_sum  = result_q;
    assign rsp_cout = carry_q;
    assign rsp_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule
